hex_count_source: RTL and testbench
===================================

// Module: hex_count_source
// PURPOSE
//  Upstream source for the two seven-segment decoder instances on the DE10-Lite top.
//  Holds an 8-bit count that can be loaded from switches, stepped by a debounced push-button or
//  free-run at a fixed tick rate. Emits two 5-bit digit words {dp, nibble} that feed the decoder's
//  (value[3:0], dp) inputs for HEX0/HEX1.
// PARAMETERS
//  CLK_HZ      50_000_000  input clock frequency in Hz
//  TICK_HZ     2           auto-run increment rate in Hz; tick period = CLK_HZ/TICK_HZ cycles
//  DB_CYCLES   1_000_000   cycles the button must be stable before it is accepted (20 ms @ 50 MHz)
// PORTS
//  MAX10_CLK1_50  in   1   single system clock
//  RST            in   1   asynchronous, active-high reset
//  SW             in   10  raw switches: [7:0] load value, [8] load mode, [9] auto-run
//  KEY_STEP       in   1   raw push-button, active-low, bouncy
//  DIG0           out  5   {dp0, count[3:0]} to low-digit decoder
//  DIG1           out  5   {dp1, count[7:4]} to high-digit decoder
//  MODE_LED       out  2   current state encoding, for LEDR[9:8]
// BEHAVIOUR
//  - Reset: count=8'h00, state=MANUAL, DIG0=5'h00, DIG1=5'h00, MODE_LED=2'b00,
//    tick counter=0, debouncer stable value=1 (released), wrap flag=0.
//  - SW and KEY_STEP pass through 2-flop synchronizers (2-cycle latency) before any use.
//  - Debounce: the synced key must hold a new level for DB_CYCLES consecutive cycles before the
//    stable value changes. A 1->0 change of the stable value raises step_pulse for exactly 1 cycle.
//  - States (MODE_LED): MANUAL=00, RUN=01, LOAD=10. Next state is evaluated every cycle from the
//    synced switches:
//      SW[8]=1 -> LOAD (highest priority)
//      else SW[9]=1 -> RUN
//      else -> MANUAL
//  - LOAD: count <= SW[7:0] every cycle; step_pulse and tick are ignored; tick counter is held at 0.
//  - RUN: tick counter counts 0..CLK_HZ/TICK_HZ-1 and wraps. tick=1 on the wrap cycle.
//    On tick, count <= count+1.
//  - MANUAL: step_pulse -> count <= count+1. Tick counter is held at 0.
//  - RUN with step_pulse: also increments. If tick and step_pulse coincide, count advances by
//    exactly 1, never 2.
//  - Arithmetic is 8-bit modulo: 8'hFF+1 = 8'h00. The increment that wraps sets the wrap flag.
//    Any later increment or any LOAD clears it.
//  - dp0 = wrap flag. dp1 = 1 while state==RUN.
//  - DIG0/DIG1/MODE_LED are registered: they reflect count/state one cycle after the update edge.
//  - Latency:
//      key release-to-press edge at the pin -> count change visible = 2 + DB_CYCLES + 1 (+1 output reg).
//      Switch change -> state change = 3 cycles.
//  - RST asserted mid-operation (mid-debounce, mid-tick): all registers return to reset values
//    immediately. A pending press is discarded and the key must be re-accepted after RST falls.
//  - Leaving RUN mid-period discards the partial tick count. Re-entering RUN waits a full period.
// STRUCTURE
//  - Shared package/header (hex_count_pkg): state encodings ST_MANUAL/ST_RUN/ST_LOAD (2-bit) and
//    DIGIT_W=5.
//  - One sub-module, key_debounce: sync + stability counter + falling-edge pulse,
//    parameter DB_CYCLES. Everything else (mode FSM, tick divider, counter, output regs) is in the
//    top body. Counter widths are derived with $clog2.
// TESTING  (bench parameters: CLK_HZ=100, TICK_HZ=10 -> 10-cycle tick, DB_CYCLES=4)
//  1. RST high with SW=0x3A5 and KEY toggling -> DIG0=00, DIG1=00, MODE_LED=00.
//     Release RST, SW=0 -> outputs stay 0.
//  2. SW[8]=1, SW[7:0]=8'hC7 -> within 4 cycles DIG1=5'h0C, DIG0=5'h07, MODE_LED=10.
//     Bouncing KEY meanwhile -> no change.
//  3. MANUAL, count=8'h12. KEY low 2 cycles/high 1/low 6 -> exactly one increment, DIG0=5'h03.
//     A KEY low pulse of 3 cycles -> no increment.
//  4. SW[8]=1 with SW[7:0]=8'hFE, then SW=10'h200 (RUN) -> DIG1 dp=1.
//     After 2 ticks (20 cycles): count=8'h00, DIG0=5'h10 (dp0 set).
//     Next tick: DIG0=5'h01, dp0 cleared.
//  5. RUN, step_pulse aligned to the tick cycle -> count advances by exactly 1.
//  6. RST pulsed mid-tick and mid-debounce -> immediate reset values. The first tick after RUN
//     resumes comes a full 10 cycles later. The held KEY is accepted only after 4 stable cycles.

Source files
------------

// File: rtl/hex_count_pkg.sv
// Shared definitions for the DE10-Lite hex counter source: mode encodings,
// digit word width and the switch-to-mode priority rule.
package hex_count_pkg;

  typedef enum logic [1:0] {
    ST_MANUAL = 2'b00,
    ST_RUN    = 2'b01,
    ST_LOAD   = 2'b10
  } state_e;

  localparam int DIGIT_W = 5;

  // Load switch wins over run switch; neither selects manual stepping.
  function automatic state_e mode_select(input logic load_sw, input logic run_sw);
    state_e mode;
    mode = ST_MANUAL;
    if (load_sw) begin
      mode = ST_LOAD;
    end else if (run_sw) begin
      mode = ST_RUN;
    end
    return mode;
  endfunction

endpackage

// File: rtl/hex_count_source_key_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and a one-cycle
// pulse when the accepted level goes from released (1) to pressed (0).
module key_debounce
  import hex_count_pkg::*;
#(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic step_pulse
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic             key_meta_q, key_meta_d;
  logic             key_sync_q, key_sync_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  always_comb begin
    key_meta_d = key_n;
    key_sync_d = key_meta_q;
    stable_d   = stable_q;
    cnt_d      = '0;
    pulse_d    = 1'b0;
    // Count consecutive cycles that disagree with the accepted level; any
    // agreeing cycle restarts the count.
    if (key_sync_q != stable_q) begin
      if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
        stable_d = key_sync_q;
        pulse_d  = stable_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_meta_q <= 1'b1;
      key_sync_q <= 1'b1;
      stable_q   <= 1'b1;
      cnt_q      <= '0;
      pulse_q    <= 1'b0;
    end else begin
      key_meta_q <= key_meta_d;
      key_sync_q <= key_sync_d;
      stable_q   <= stable_d;
      cnt_q      <= cnt_d;
      pulse_q    <= pulse_d;
    end
  end

  assign step_pulse = pulse_q;

endmodule

// File: rtl/hex_count_source.sv
// 8-bit counter feeding two seven-segment digit words: switch load, debounced
// manual stepping or free-running tick increments, with a wrap indicator.
module hex_count_source
  import hex_count_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TICK_HZ   = 2,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic               MAX10_CLK1_50,
  input  logic               RST,
  input  logic [9:0]         SW,
  input  logic               KEY_STEP,
  output logic [DIGIT_W-1:0] DIG0,
  output logic [DIGIT_W-1:0] DIG1,
  output logic [1:0]         MODE_LED
);

  localparam int TICK_PERIOD = CLK_HZ / TICK_HZ;
  localparam int TICK_W      = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;

  logic                clk;
  logic                step_pulse;
  logic                tick;

  logic [9:0]          sw_meta_q, sw_meta_d;
  logic [9:0]          sw_sync_q, sw_sync_d;
  state_e              state_q, state_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [7:0]          count_q, count_d;
  logic                wrap_q, wrap_d;
  logic [DIGIT_W-1:0]  dig0_q, dig0_d;
  logic [DIGIT_W-1:0]  dig1_q, dig1_d;
  logic [1:0]          mode_led_q, mode_led_d;

  assign clk = MAX10_CLK1_50;

  key_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_key_debounce (
    .clk        (clk),
    .rst        (RST),
    .key_n      (KEY_STEP),
    .step_pulse (step_pulse)
  );

  always_comb begin
    sw_meta_d = SW;
    sw_sync_d = sw_meta_q;

    // The mode chosen this cycle also governs this cycle's counter update,
    // so a load takes effect on the same edge the state changes.
    state_d = mode_select(sw_sync_q[8], sw_sync_q[9]);

    tick       = 1'b0;
    tick_cnt_d = '0;
    if (state_d == ST_RUN) begin
      if (tick_cnt_q == TICK_W'(TICK_PERIOD - 1)) begin
        tick = 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + 1'b1;
      end
    end

    count_d = count_q;
    wrap_d  = wrap_q;
    if (state_d == ST_LOAD) begin
      count_d = sw_sync_q[7:0];
      wrap_d  = 1'b0;
    end else if (step_pulse || tick) begin
      count_d = count_q + 8'd1;
      wrap_d  = (count_q == 8'hFF);
    end

    dig0_d     = {wrap_q, count_q[3:0]};
    dig1_d     = {state_q == ST_RUN, count_q[7:4]};
    mode_led_d = state_q;
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      state_q    <= ST_MANUAL;
      tick_cnt_q <= '0;
      count_q    <= 8'h00;
      wrap_q     <= 1'b0;
      dig0_q     <= '0;
      dig1_q     <= '0;
      mode_led_q <= 2'b00;
    end else begin
      sw_meta_q  <= sw_meta_d;
      sw_sync_q  <= sw_sync_d;
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      dig0_q     <= dig0_d;
      dig1_q     <= dig1_d;
      mode_led_q <= mode_led_d;
    end
  end

  assign DIG0     = dig0_q;
  assign DIG1     = dig1_q;
  assign MODE_LED = mode_led_q;

endmodule

// File: tb/tb_hex_count_source.sv
// Bench for hex_count_source: directed scenarios plus random stimulus, checked
// every cycle against a cycle-level behavioural model of the counter.
module tb_hex_count_source;

  localparam int DB       = 4;
  localparam int TICK_CYC = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] sw  = '0;
  logic       key = 1'b1;
  logic [4:0] dig0, dig1;
  logic [1:0] mode_led;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic [9:0]  sw_hist[$];
  logic        key_hist[$];
  logic        key_seen[$];
  logic        m_stable, m_pulse_pending, m_wrap;
  logic [7:0]  m_count;
  logic [1:0]  m_mode_prev;
  int          m_run_edges;
  logic [11:0] exp_q[$];
  logic [11:0] exp;

  hex_count_source #(
    .CLK_HZ    (100),
    .TICK_HZ   (10),
    .DB_CYCLES (DB)
  ) dut (
    .MAX10_CLK1_50 (clk),
    .RST           (rst),
    .SW            (sw),
    .KEY_STEP      (key),
    .DIG0          (dig0),
    .DIG1          (dig1),
    .MODE_LED      (mode_led)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] obs();
    return {dig1, dig0, mode_led};
  endfunction

  task automatic model_reset();
    sw_hist.delete();
    key_hist.delete();
    key_seen.delete();
    exp_q.delete();
    sw_hist.push_back(10'h000);
    sw_hist.push_back(10'h000);
    key_hist.push_back(1'b1);
    key_hist.push_back(1'b1);
    m_stable        = 1'b1;
    m_pulse_pending = 1'b0;
    m_wrap          = 1'b0;
    m_count         = 8'h00;
    m_mode_prev     = 2'd0;
    m_run_edges     = 0;
  endtask

  // One rising edge: pins seen two edges ago drive the logic; outputs show the
  // values held before this edge.
  task automatic model_edge(input logic [9:0] sw_pin, input logic key_pin);
    logic [9:0] s_sw;
    logic       s_key, pulse_now, tick, all_diff;
    logic [1:0] mode;
    exp_q.push_back({m_mode_prev == 2'd1, m_count[7:4], m_wrap, m_count[3:0], m_mode_prev});
    sw_hist.push_back(sw_pin);
    key_hist.push_back(key_pin);
    s_sw  = sw_hist.pop_front();
    s_key = key_hist.pop_front();
    pulse_now       = m_pulse_pending;
    m_pulse_pending = 1'b0;
    key_seen.push_back(s_key);
    if (key_seen.size() > DB) void'(key_seen.pop_front());
    if (key_seen.size() == DB) begin
      all_diff = 1'b1;
      foreach (key_seen[j]) if (key_seen[j] == m_stable) all_diff = 1'b0;
      if (all_diff) begin
        if (m_stable) m_pulse_pending = 1'b1;
        m_stable = ~m_stable;
      end
    end
    mode = s_sw[8] ? 2'd2 : (s_sw[9] ? 2'd1 : 2'd0);
    m_run_edges = (mode == 2'd1) ? m_run_edges + 1 : 0;
    tick = (mode == 2'd1) && (m_run_edges % TICK_CYC == 0);
    if (mode == 2'd2) begin
      m_count = s_sw[7:0];
      m_wrap  = 1'b0;
    end else if (pulse_now || tick) begin
      m_wrap  = (m_count == 8'hFF);
      m_count = m_count + 8'd1;
    end
    m_mode_prev = mode;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge(sw, key);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sw  = 10'h3A5;
    for (int i = 0; i < 6; i++) begin
      key = ~key;
      cycle();
      n_cmp++;
      if (obs() !== 12'h000) begin
        n_fail++;
        $display("FAIL reset_hold c%0d: got %h want 000", i, obs());
      end
    end
    rst = 1'b0;
    sw  = '0;
    key = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      exp = exp_q.pop_front();
      n_cmp++;
      if (obs() !== exp || obs() !== 12'h000) begin
        n_fail++;
        $display("FAIL reset_release c%0d: got %h want %h", i, obs(), exp);
      end
    end
  endtask

  task automatic test_load();
    sw = 10'h1C7;
    for (int i = 1; i <= 10; i++) begin
      key = 1'($urandom_range(0, 1));
      cycle();
      exp = exp_q.pop_front();
      n_cmp++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL load c%0d: got %h want %h", i, obs(), exp);
      end
      if (i == 4) begin
        n_cmp++;
        if (obs() !== {5'h0C, 5'h07, 2'b10}) begin
          n_fail++;
          $display("FAIL load_latency: got %h want %h", obs(), {5'h0C, 5'h07, 2'b10});
        end
      end
    end
    key = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      exp = exp_q.pop_front();
      n_cmp++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL load_settle c%0d: got %h want %h", i, obs(), exp);
      end
    end
  endtask

  task automatic test_manual_step();
    logic pat_a[$];
    logic pat_b[$];
    pat_a = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    pat_b = '{1'b0, 1'b0, 1'b0,
              1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 10; i++) begin
      sw  = (i < 5) ? 10'h112 : 10'h000;
      key = 1'b1;
      cycle();
      exp = exp_q.pop_front();
      n_cmp++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL manual_setup c%0d: got %h want %h", i, obs(), exp);
      end
    end
    foreach (pat_a[i]) begin
      key = pat_a[i];
      cycle();
      exp = exp_q.pop_front();
      n_cmp++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL manual_press c%0d: got %h want %h", i, obs(), exp);
      end
    end
    n_cmp++;
    if (obs() !== {5'h01, 5'h03, 2'b00}) begin
      n_fail++;
      $display("FAIL manual_one_step: got %h want %h", obs(), {5'h01, 5'h03, 2'b00});
    end
    foreach (pat_b[i]) begin
      key = pat_b[i];
      cycle();
      exp = exp_q.pop_front();
      n_cmp++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL manual_short c%0d: got %h want %h", i, obs(), exp);
      end
    end
    n_cmp++;
    if (obs() !== {5'h01, 5'h03, 2'b00}) begin
      n_fail++;
      $display("FAIL manual_short_ignored: got %h want %h", obs(), {5'h01, 5'h03, 2'b00});
    end
  endtask

  task automatic test_run_wrap();
    logic [11:0] want;
    key = 1'b1;
    sw  = 10'h1FE;
    for (int i = 0; i < 5; i++) begin
      cycle();
      exp = exp_q.pop_front();
      n_cmp++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL run_load c%0d: got %h want %h", i, obs(), exp);
      end
    end
    sw = 10'h200;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      exp = exp_q.pop_front();
      n_cmp++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL run_wrap c%0d: got %h want %h", i, obs(), exp);
      end
      if (i == 4 || i == 23 || i == 33) begin
        case (i)
          4:       want = {5'h1F, 5'h0E, 2'b01};
          23:      want = {5'h10, 5'h10, 2'b01};
          default: want = {5'h10, 5'h01, 2'b01};
        endcase
        n_cmp++;
        if (obs() !== want) begin
          n_fail++;
          $display("FAIL run_wrap_point c%0d: got %h want %h", i, obs(), want);
        end
      end
    end
  endtask

  // Presses every 11 cycles against a 10-cycle tick sweep every phase,
  // including a press landing on the tick edge.
  task automatic test_tick_step();
    sw = 10'h200;
    for (int p = 0; p < 10; p++) begin
      for (int i = 0; i < 11; i++) begin
        key = (i < 6) ? 1'b0 : 1'b1;
        cycle();
        exp = exp_q.pop_front();
        n_cmp++;
        if (obs() !== exp) begin
          n_fail++;
          $display("FAIL tick_step p%0d c%0d: got %h want %h", p, i, obs(), exp);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] want;
    sw  = 10'h200;
    key = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (i >= 13) key = 1'b0;
      cycle();
      exp = exp_q.pop_front();
      n_cmp++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL mid_pre c%0d: got %h want %h", i, obs(), exp);
      end
    end
    rst = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if (obs() !== 12'h000) begin
      n_fail++;
      $display("FAIL mid_async: got %h want 000", obs());
    end
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_cmp++;
      if (obs() !== 12'h000) begin
        n_fail++;
        $display("FAIL mid_hold c%0d: got %h want 000", i, obs());
      end
    end
    rst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      exp = exp_q.pop_front();
      n_cmp++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL mid_resume c%0d: got %h want %h", i, obs(), exp);
      end
      if (i == 7 || i == 8 || i == 12 || i == 13) begin
        case (i)
          7:       want = {5'h10, 5'h00, 2'b01};
          13:      want = {5'h10, 5'h02, 2'b01};
          default: want = {5'h10, 5'h01, 2'b01};
        endcase
        n_cmp++;
        if (obs() !== want) begin
          n_fail++;
          $display("FAIL mid_resume_point c%0d: got %h want %h", i, obs(), want);
        end
      end
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int i = 0; i < 500; i++) begin
      if (i % 25 == 0) begin
        sw = {2'($urandom_range(0, 3)), 8'($urandom)};
      end
      if (hold == 0) begin
        key  = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 7);
      end
      hold--;
      if ($urandom_range(0, 149) == 0) begin
        rst = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if (obs() !== 12'h000) begin
          n_fail++;
          $display("FAIL random_rst c%0d: got %h want 000", i, obs());
        end
        cycle();
        rst = 1'b0;
      end else begin
        cycle();
        exp = exp_q.pop_front();
        n_cmp++;
        if (obs() !== exp) begin
          n_fail++;
          $display("FAIL random c%0d: got %h want %h", i, obs(), exp);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load();
    test_manual_step();
    test_run_wrap();
    test_tick_step();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
